// File: rtl/cpu_result_reader.sv
// Waits for the cpu to stop (trap goes non-zero), snapshots result/result_empty/trap
// and streams them to the host as a header byte plus little-endian payload bytes.
module cpu_result_reader #(
    parameter logic [3:0] MAGIC        = 4'hA,
    parameter int         RESULT_BYTES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] result,
    input  logic        result_empty,
    input  logic [2:0]  trap,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state_o
);

    localparam int CNT_W = (RESULT_BYTES > 1) ? $clog2(RESULT_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RESULT_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      result_s_q, result_s_d;
    logic             empty_s_q, empty_s_d;
    logic [2:0]       trap_s_q, trap_s_d;
    logic [2:0]       trap_q;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             stop_event;
    logic             handshake;
    logic [7:0]       payload_byte;

    // Valid/ready: a byte moves when tx_valid & tx_ready at a rising edge; until then
    // tx_valid stays high and tx_data stays put, since both are driven from registers.
    assign stop_event = (trap != 3'd0) && (trap_q == 3'd0);
    assign handshake  = tx_valid_q && tx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            result_s_q <= '0;
            empty_s_q  <= 1'b0;
            trap_s_q   <= 3'd0;
            trap_q     <= 3'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            result_s_q <= result_s_d;
            empty_s_q  <= empty_s_d;
            trap_s_q   <= trap_s_d;
            trap_q     <= trap;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        result_s_d = result_s_q;
        empty_s_d  = empty_s_q;
        trap_s_d   = trap_s_q;
        case (state_q)
            S_IDLE: begin
                if (stop_event) begin
                    result_s_d = result;
                    empty_s_d  = result_empty;
                    trap_s_d   = trap;
                    state_d    = S_HEADER;
                end
            end
            S_HEADER: begin
                if (handshake) begin
                    cnt_d   = '0;
                    state_d = empty_s_q ? S_DONE : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (handshake) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (trap == 3'd0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are precomputed from the next state so the registered byte lines up with it.
    always_comb begin
        payload_byte = 8'd0;
        for (int i = 0; i < RESULT_BYTES; i++) begin
            if (cnt_d == CNT_W'(i)) payload_byte = result_s_d[8*i +: 8];
        end
        tx_valid_d = 1'b0;
        tx_data_d  = 8'd0;
        case (state_d)
            S_HEADER: begin
                tx_valid_d = 1'b1;
                tx_data_d  = {MAGIC, empty_s_d, trap_s_d};
            end
            S_PAYLOAD: begin
                tx_valid_d = 1'b1;
                tx_data_d  = payload_byte;
            end
            default: begin
                tx_valid_d = 1'b0;
                tx_data_d  = 8'd0;
            end
        endcase
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = (state_q == S_HEADER) || (state_q == S_PAYLOAD);
    assign done        = (state_q == S_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cpu_result_reader.sv
// Bench for cpu_result_reader: table of frames, reset-mid-frame sequence and random
// frames, all checked against a byte-frame model built from the frame format.
module tb_cpu_result_reader;

    localparam int RB = 8;

    logic        clk;
    logic        reset;
    logic [63:0] result;
    logic        result_empty;
    logic [2:0]  trap;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    logic [7:0] exp_q[$];
    int n_pass;
    int n_total;

    typedef struct {
        logic [2:0]  trap;
        logic        emp;
        logic [63:0] res;
        int          mode;     // 0 ready high, 1 toggle 1010, 2 random
        int          corrupt;  // 0 none, 1 scramble inputs mid-frame, 2 trap->0 mid-frame
        logic [7:0]  hdr;
        int          len;
    } vec_t;

    vec_t vecs[6];

    cpu_result_reader dut (
        .clk          (clk),
        .reset        (reset),
        .result       (result),
        .result_empty (result_empty),
        .trap         (trap),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .done         (done),
        .dbg_state_o  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    // Model: a frame is the header {A, empty, trap} then RB result bytes, LSB first, unless empty.
    task automatic build_expected(input logic [2:0] tr, input logic emp, input logic [63:0] res);
        exp_q.push_back({4'hA, emp, tr});
        if (!emp) begin
            for (int i = 0; i < RB; i++) exp_q.push_back(res[8*i +: 8]);
        end
    endtask

    task automatic start_frame(input logic [2:0] tr, input logic emp, input logic [63:0] res);
        trap         = tr;
        result_empty = emp;
        result       = res;
        build_expected(tr, emp, res);
    endtask

    task automatic consume(input int mode, input int corrupt, input int len_expect, input logic [7:0] hdr);
        int cyc = 0;
        int accepted = 0;
        int first_valid = -1;
        int last_acc = -1;
        bit hold_chk = 1'b0;
        logic [7:0] held = 8'd0;
        logic [7:0] want;
        while (exp_q.size() > 0 && cyc < 200) begin
            @(negedge clk);
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 2 == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (hold_chk) check(tx_valid && tx_data == held, "hold_stable", {tx_valid, tx_data}, {1'b1, held});
            hold_chk = 1'b0;
            if (tx_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (tx_ready) begin
                    want = exp_q.pop_front();
                    if (accepted == 0) check(tx_data == hdr, "header", tx_data, hdr);
                    else check(tx_data == want, "payload_byte", tx_data, want);
                    accepted++;
                    last_acc = cyc;
                    if (accepted == 1 && corrupt == 1) begin
                        result       = '1;
                        trap         = 3'd3;
                        result_empty = ~result_empty;
                    end
                    if (accepted == 2 && corrupt == 2) trap = 3'd0;
                end else begin
                    hold_chk = 1'b1;
                    held     = tx_data;
                end
            end
            cyc++;
        end
        if (exp_q.size() > 0) begin
            check(1'b0, "frame_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        check(first_valid == 0, "hdr_latency", 64'(first_valid), 64'd0);
        if (mode == 0) check(last_acc - first_valid + 1 == len_expect, "frame_len",
                             64'(last_acc - first_valid + 1), 64'(len_expect));
        tx_ready = 1'b1;
        @(negedge clk);
        check(done && !busy && !tx_valid, "done_after", {done, busy, tx_valid}, 3'b100);
    endtask

    task automatic rearm();
        if (trap != 3'd0) begin
            @(negedge clk);
            check(done == 1'b1, "done_hold", done, 1'b1);
            trap = 3'd0;
        end
        @(negedge clk);
        check(!done && !busy && !tx_valid, "rearm_idle", {done, busy, tx_valid}, 3'b000);
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        reset        = 1'b1;
        result       = '0;
        result_empty = 1'b0;
        trap         = 3'd0;
        tx_ready     = 1'b1;

        vecs[0] = '{3'd1, 1'b0, 64'h0807060504030201, 0, 0, 8'hA1, 9};
        vecs[1] = '{3'd2, 1'b1, 64'h0807060504030201, 0, 0, 8'hAA, 1};
        vecs[2] = '{3'd1, 1'b0, 64'h0807060504030201, 1, 0, 8'hA1, 9};
        vecs[3] = '{3'd5, 1'b0, 64'h1122334455667788, 0, 1, 8'hA5, 9};
        vecs[4] = '{3'd1, 1'b0, 64'h0000000000000001, 0, 0, 8'hA1, 9};
        vecs[5] = '{3'd7, 1'b0, 64'hCAFEBABEDEADBEEF, 2, 2, 8'hA7, 9};

        repeat (3) @(negedge clk);
        check(tx_valid == 1'b0, "rst_tx_valid", tx_valid, 1'b0);
        check(tx_data == 8'd0, "rst_tx_data", tx_data, 8'd0);
        check(busy == 1'b0, "rst_busy", busy, 1'b0);
        check(done == 1'b0, "rst_done", done, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            start_frame(vecs[v].trap, vecs[v].emp, vecs[v].res);
            consume(vecs[v].mode, vecs[v].corrupt, vecs[v].len, vecs[v].hdr);
            rearm();
        end

        // Reset while PAYLOAD byte 3 is on the bus, then release with trap still held.
        start_frame(3'd1, 1'b0, 64'h0807060504030201);
        tx_ready = 1'b1;
        repeat (5) @(negedge clk);
        check(tx_valid && tx_data == 8'h04, "pre_reset_byte3", {tx_valid, tx_data}, {1'b1, 8'h04});
        #2 reset = 1'b1;
        #1;
        check(!tx_valid && tx_data == 8'd0 && !busy && !done, "async_reset",
              {tx_valid, tx_data, busy, done}, 11'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        build_expected(3'd1, 1'b0, 64'h0807060504030201);
        consume(0, 0, 9, 8'hA1);
        rearm();

        for (int r = 0; r < 30; r++) begin
            logic [2:0]  rt;
            logic        re;
            logic [63:0] rr;
            int          rm;
            int          rc;
            rt = 3'($urandom_range(1, 7));
            re = ($urandom_range(0, 3) == 0);
            rr = {$urandom, $urandom};
            rm = $urandom_range(0, 2);
            rc = $urandom_range(0, 2);
            start_frame(rt, re, rr);
            consume(rm, rc, re ? 1 : 1 + RB, {4'hA, re, rt});
            rearm();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
